// File: rtl/ifu.sv
// Instruction fetch unit: issues sequential fetches to a 1-cycle-latency instruction
// memory and queues the returned words in a small circular buffer that feeds decode.
module ifu #(
  parameter logic [31:0] RST_PC    = 32'h0800_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iram_rstn_i,
  output logic [31:0] pc_n_o,
  output logic        iram_rd_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic [31:0]      fpc_q, fpc_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  entry_t           buf_q [BUF_DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W-1:0] occupancy;
  entry_t           head;
  logic             unused_jump_lsb;

  // Word alignment of the redirect target discards the two low bits.
  assign unused_jump_lsb = ^jump_addr_i[1:0];

  assign head         = buf_q[rd_ptr_q];
  assign inst_valid_o = (count_q != '0);
  assign inst_o       = head.inst;
  assign inst_pc_o    = head.pc;
  assign pc_n_o       = fpc_q;

  assign pop       = inst_valid_o & inst_ready_i;
  assign occupancy = count_q + CNT_W'(inflight_q);
  // Counting the inflight response in occupancy is what keeps a push from ever
  // landing on a full buffer, so the memory never needs to be stalled mid-return.
  assign issue     = ~iram_rstn_i & ~jump_i & ((occupancy < FULL) | pop);
  assign push      = inflight_q & ~jump_i;
  assign iram_rd_o = issue;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fpc_d      = fpc_q;
    inflight_d = issue;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (jump_i) begin
      fpc_d    = {jump_addr_i[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (issue) fpc_d = fpc_q + 32'd4;
      if (push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of its neighbours regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q      <= RST_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // NOTE: the buffer storage is reset on purpose so inst_o/inst_pc_o read zero until
  // the first push; it is only a few entries, so flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else if (push) begin
      buf_q[wr_ptr_q] <= '{pc: pc_i, inst: inst_i};
    end
  end

`ifndef SYNTHESIS
  push_while_full_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == FULL)))
    else $error("ifu: push into full instruction buffer");
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: startup, backpressure, redirects, address wrap and mid-run reset,
// against a 1-cycle instruction memory model that holds its output when not read.
module tb_ifu;

  localparam logic [31:0] RST_PC = 32'h0800_0000;

  logic        clk;
  logic        rst_n;
  logic        iram_rstn_i;
  logic [31:0] pc_n_o;
  logic        iram_rd_o;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] issues;

  ifu #(.RST_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iram_rstn_i  (iram_rstn_i),
    .pc_n_o       (pc_n_o),
    .iram_rd_o    (iram_rd_o),
    .pc_i         (pc_i),
    .inst_i       (inst_i),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) begin
    if (iram_rd_o) begin
      pc_i   <= pc_n_o;
      inst_i <= mem_word(pc_n_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; iram_rstn_i = 1'b1; jump_i = 1'b0;
    jump_addr_i = '0; inst_ready_i = 1'b1;

    // Reset state
    tick(); #1;
    check("rst_pc",    pc_n_o, RST_PC);
    check("rst_rd",    32'(iram_rd_o), 32'd0);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst",  inst_o, 32'd0);
    check("rst_ipc",   inst_pc_o, 32'd0);
    rst_n = 1'b1;

    // Memory busy for one cycle after release: no fetch, fpc held
    tick(); #1;
    check("busy_rd", 32'(iram_rd_o), 32'd0);
    check("busy_pc", pc_n_o, RST_PC);
    iram_rstn_i = 1'b0; #1;
    check("first_rd", 32'(iram_rd_o), 32'd1);
    check("first_pc", pc_n_o, RST_PC);
    tick(); #1;
    check("second_pc",   pc_n_o, RST_PC + 32'd4);
    check("lat_valid",   32'(inst_valid_o), 32'd0);
    tick(); #1;
    check("third_pc", pc_n_o, RST_PC + 32'd8);
    for (int k = 0; k < 4; k++) begin
      check("stream_valid", 32'(inst_valid_o), 32'd1);
      check("stream_ipc",   inst_pc_o, RST_PC + 32'(4 * k));
      check("stream_inst",  inst_o, mem_word(RST_PC + 32'(4 * k)));
      tick(); #1;
    end

    // Backpressure from an empty buffer: exactly two issues, then hold
    jump_i = 1'b1; jump_addr_i = 32'h0000_0200; inst_ready_i = 1'b0; #1;
    check("jump_rd_low", 32'(iram_rd_o), 32'd0);
    tick(); jump_i = 1'b0; #1;
    issues = '0;
    for (int i = 0; i < 5; i++) begin
      if (iram_rd_o) begin
        check("bp_issue_pc", pc_n_o, 32'h0000_0200 + (issues << 2));
        issues = issues + 32'd1;
      end
      tick(); #1;
    end
    check("bp_issues", issues, 32'd2);
    check("bp_rd",     32'(iram_rd_o), 32'd0);
    check("bp_hold",   pc_n_o, 32'h0000_0208);
    check("bp_valid",  32'(inst_valid_o), 32'd1);
    inst_ready_i = 1'b1; #1;
    check("bp_resume_rd", 32'(iram_rd_o), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", 32'(inst_valid_o), 32'd1);
      check("drain_ipc",   inst_pc_o, 32'h0000_0200 + 32'(4 * k));
      tick(); #1;
    end

    // Redirect while a response returns: response dropped, target aligned
    jump_i = 1'b1; jump_addr_i = 32'h0000_0102; #1;
    check("j1_rd", 32'(iram_rd_o), 32'd0);
    tick(); jump_i = 1'b0; #1;
    check("j1_valid0", 32'(inst_valid_o), 32'd0);
    check("j1_rd_next", 32'(iram_rd_o), 32'd1);
    check("j1_pc",     pc_n_o, 32'h0000_0100);
    tick(); #1;
    check("j1_valid1", 32'(inst_valid_o), 32'd0);
    tick(); #1;
    check("j1_valid2", 32'(inst_valid_o), 32'd1);
    check("j1_ipc",    inst_pc_o, 32'h0000_0100);
    check("j1_inst",   inst_o, mem_word(32'h0000_0100));

    // Fill to two entries, then redirect and pop in the same cycle
    inst_ready_i = 1'b0; #1;
    check("fill_pc", pc_n_o, 32'h0000_0108);
    tick(); #1;
    check("full_rd",   32'(iram_rd_o), 32'd0);
    check("full_hold", pc_n_o, 32'h0000_0108);
    check("full_ipc",  inst_pc_o, 32'h0000_0100);
    jump_i = 1'b1; jump_addr_i = 32'h0000_0300; inst_ready_i = 1'b1; #1;
    check("j2_rd", 32'(iram_rd_o), 32'd0);
    tick(); jump_i = 1'b0; #1;
    check("j2_valid0", 32'(inst_valid_o), 32'd0);
    check("j2_pc",     pc_n_o, 32'h0000_0300);
    tick(); #1;
    check("j2_valid1", 32'(inst_valid_o), 32'd0);
    tick(); #1;
    check("j2_valid2", 32'(inst_valid_o), 32'd1);
    check("j2_ipc",    inst_pc_o, 32'h0000_0300);

    // Address wrap at the top of the space
    jump_i = 1'b1; jump_addr_i = 32'hFFFF_FFF8; #1;
    tick(); jump_i = 1'b0; #1;
    check("wrap_pc0", pc_n_o, 32'hFFFF_FFF8);
    tick(); #1;
    check("wrap_pc1", pc_n_o, 32'hFFFF_FFFC);
    tick(); #1;
    check("wrap_pc2", pc_n_o, 32'h0000_0000);
    check("wrap_ipc0", inst_pc_o, 32'hFFFF_FFF8);
    tick(); #1;
    check("wrap_ipc1", inst_pc_o, 32'hFFFF_FFFC);
    tick(); #1;
    check("wrap_ipc2", inst_pc_o, 32'h0000_0000);
    check("wrap_inst2", inst_o, mem_word(32'h0000_0000));

    // Reset mid-stream with an entry buffered and a response inflight
    rst_n = 1'b0; iram_rstn_i = 1'b1; #1;
    check("mrst_valid", 32'(inst_valid_o), 32'd0);
    check("mrst_rd",    32'(iram_rd_o), 32'd0);
    check("mrst_pc",    pc_n_o, RST_PC);
    check("mrst_ipc",   inst_pc_o, 32'd0);
    check("mrst_inst",  inst_o, 32'd0);
    tick(); #1;
    rst_n = 1'b1;
    tick(); #1;
    check("mrel_valid", 32'(inst_valid_o), 32'd0);
    check("mrel_pc",    pc_n_o, RST_PC);
    iram_rstn_i = 1'b0; #1;
    check("mrel_rd", 32'(iram_rd_o), 32'd1);
    tick(); #1;
    check("mrel_valid1", 32'(inst_valid_o), 32'd0);
    tick(); #1;
    check("mrel_valid2", 32'(inst_valid_o), 32'd1);
    check("mrel_ipc",    inst_pc_o, RST_PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
